// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: instruction
// encodings, instruction memory geometry and fetch FSM state encodings.
package instruction_fetch_pkg;

   // Datapath width of instructions and program counter
   localparam int XLEN = 32;

   // Instruction memory geometry: 256 words, byte address bits [9:2]
   localparam int IMEM_AW    = 8;
   localparam int IMEM_DEPTH = 1 << IMEM_AW;

   // Special instruction encodings
   localparam logic [XLEN-1:0] INSTR_NOP  = 32'h0000_0000;
   localparam logic [XLEN-1:0] INSTR_HALT = 32'hFFFF_FFFF;

   // Fetch FSM states; encodings are visible on o_state
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } fetch_state_t;

   // Word index into the instruction memory for a byte PC (wraps every 1 KB)
   function automatic logic [IMEM_AW-1:0] pc_to_index(input logic [XLEN-1:0] pc);
      return pc[IMEM_AW+1:2];
   endfunction

endpackage

// File: rtl/instruction_memory.sv
// 256x32 instruction memory: synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded program survives reset.
module instruction_memory
   import instruction_fetch_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [IMEM_AW-1:0] i_waddr,
   input  logic [XLEN-1:0]    i_wdata,
   input  logic [IMEM_AW-1:0] i_raddr,
   output logic [XLEN-1:0]    o_rdata
);

   logic [XLEN-1:0] r_mem [IMEM_DEPTH];

   // Program-load write port
   // NOTE: the array has no reset branch on purpose: clearing 256 words would
   // both destroy the loaded program and prevent mapping onto RAM primitives.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Combinational read so the fetch completes within the PC cycle
   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALTED FSM, IF/ID pipeline
// register and the program-load path into the instruction memory.
//
// Build option: define IF_JUMP_FLUSH_EN to flush the IF/ID register with a
// NOP on a taken jump (no delay slot; a HALT fetched alongside is squashed).
// Without it the sequentially fetched word fills one delay slot and a HALT
// found there still stops the stage.
module instruction_fetch
   import instruction_fetch_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic            i_stall,
   input  logic            i_jump,
   input  logic [31:0]     i_jump_address,
   input  logic            i_load_en,
   input  logic [7:0]      i_load_addr,
   input  logic [31:0]     i_load_data,
   output logic [31:0]     o_instruction,
   output logic [31:0]     o_pc,
   output logic            o_halt,
   output logic [1:0]      o_state
);

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;

   // IF/ID pipeline register
   logic [XLEN-1:0] r_instruction;
   logic [XLEN-1:0] r_pc_plus4;
   logic            r_halt;
   logic [XLEN-1:0] w_instruction_nxt;
   logic [XLEN-1:0] w_pc_plus4_nxt;
   logic            w_halt_nxt;

   logic [XLEN-1:0] w_fetch_word;
   logic [XLEN-1:0] w_pc_seq;
   logic [XLEN-1:0] w_jump_target;
   logic            w_is_halt;
   logic            w_mem_we;

   // Jump targets are word aligned; the two low address bits are dropped
   logic            w_unused_jump_lsbs;
   assign w_unused_jump_lsbs = ^i_jump_address[1:0];

   assign w_pc_seq      = r_pc + 32'd4;
   assign w_jump_target = {i_jump_address[31:2], 2'b00};
   assign w_is_halt     = (w_fetch_word == INSTR_HALT);

   // Program loading is only permitted while the stage is not fetching
   assign w_mem_we = i_load_en && (r_state != ST_RUN);

   instruction_memory u_imem (
      .i_clk   (i_clk),
      .i_we    (w_mem_we),
      .i_waddr (i_load_addr),
      .i_wdata (i_load_data),
      .i_raddr (pc_to_index(r_pc)),
      .o_rdata (w_fetch_word)
   );

   // FSM state register
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // sample pre-edge values and simulation order cannot change the result.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, next PC and next IF/ID contents (stall > jump > sequential)
   // NOTE: every signal gets its hold value first so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_instruction_nxt = r_instruction;
      w_pc_plus4_nxt    = r_pc_plus4;
      w_halt_nxt        = r_halt;

      case (r_state)
         ST_IDLE, ST_HALTED: begin
            // Bubble decode while parked; a start always restarts from 0
            w_instruction_nxt = INSTR_NOP;
            w_halt_nxt        = 1'b0;
            if (i_start) begin
               w_state_nxt = ST_RUN;
               w_pc_nxt    = '0;
            end
         end

         ST_RUN: begin
            if (i_stall) begin
               // Decode hazard: hold PC and IF/ID; any jump is re-asserted later
               w_pc_nxt = r_pc;
            end else if (i_jump) begin
               w_pc_nxt = w_jump_target;
`ifdef IF_JUMP_FLUSH_EN
               // Flush the slot; a HALT fetched on the wrong path is dropped
               w_instruction_nxt = INSTR_NOP;
               w_pc_plus4_nxt    = '0;
               w_halt_nxt        = 1'b0;
`else
               // Delay slot: the sequential word still enters decode
               w_instruction_nxt = w_fetch_word;
               w_pc_plus4_nxt    = w_pc_seq;
               w_halt_nxt        = w_is_halt;
               if (w_is_halt) begin
                  w_state_nxt = ST_HALTED;
                  w_pc_nxt    = r_pc;
               end
`endif
            end else begin
               w_instruction_nxt = w_fetch_word;
               w_pc_plus4_nxt    = w_pc_seq;
               w_halt_nxt        = w_is_halt;
               if (w_is_halt) begin
                  // PC parks on the HALT word
                  w_state_nxt = ST_HALTED;
               end else begin
                  w_pc_nxt = w_pc_seq;
               end
            end
         end

         default: begin
            w_state_nxt       = ST_IDLE;
            w_pc_nxt          = '0;
            w_instruction_nxt = INSTR_NOP;
            w_pc_plus4_nxt    = '0;
            w_halt_nxt        = 1'b0;
         end
      endcase
   end

   // PC and IF/ID register; reset discards any in-flight fetch
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_pc          <= '0;
         r_instruction <= INSTR_NOP;
         r_pc_plus4    <= '0;
         r_halt        <= 1'b0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_instruction <= w_instruction_nxt;
         r_pc_plus4    <= w_pc_plus4_nxt;
         r_halt        <= w_halt_nxt;
      end
   end

   assign o_instruction = r_instruction;
   assign o_pc          = r_pc_plus4;
   assign o_halt        = r_halt;
   assign o_state       = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: program load, sequential fetch to
// HALT, stall with pending jump, jump with masking, async reset mid-run,
// load blocking in RUN, load+start in HALTED and 32-bit PC wrap.
module tb_instruction_fetch;

   logic        i_clk;
   logic        i_reset;
   logic        i_start;
   logic        i_stall;
   logic        i_jump;
   logic [31:0] i_jump_address;
   logic        i_load_en;
   logic [7:0]  i_load_addr;
   logic [31:0] i_load_data;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;
   logic        o_halt;
   logic [1:0]  o_state;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] W0   = 32'h8C22_0004;
   localparam logic [31:0] W1   = 32'h0022_1820;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] W255 = 32'h2000_00FF;
   localparam logic [31:0] WNEW = 32'hA5A5_0001;

   instruction_fetch dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_start        (i_start),
      .i_stall        (i_stall),
      .i_jump         (i_jump),
      .i_jump_address (i_jump_address),
      .i_load_en      (i_load_en),
      .i_load_addr    (i_load_addr),
      .i_load_data    (i_load_data),
      .o_instruction  (o_instruction),
      .o_pc           (o_pc),
      .o_halt         (o_halt),
      .o_state        (o_state)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
      i_load_en   = 1'b1;
      i_load_addr = addr;
      i_load_data = data;
      tick();
      i_load_en   = 1'b0;
   endtask

   task automatic start_pulse();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   initial begin
      i_reset        = 1'b0;
      i_start        = 1'b0;
      i_stall        = 1'b0;
      i_jump         = 1'b0;
      i_jump_address = '0;
      i_load_en      = 1'b0;
      i_load_addr    = '0;
      i_load_data    = '0;

      #2;
      check("rst_instr", o_instruction, 32'h0);
      check("rst_pc",    o_pc,          32'h0);
      check("rst_halt",  {31'b0, o_halt},  32'h0);
      check("rst_state", {30'b0, o_state}, 32'h0);
      #10 i_reset = 1'b1;

      // Program load in IDLE
      load_word(8'd0,   W0);
      load_word(8'd1,   W1);
      load_word(8'd2,   HALT);
      load_word(8'd255, W255);
      check("idle_state", {30'b0, o_state}, 32'h0);
      check("idle_instr", o_instruction, 32'h0);

      // Sequential fetch to HALT
      start_pulse();
      check("start_state", {30'b0, o_state}, 32'h1);
      check("start_bubble", o_instruction, 32'h0);
      tick();
      check("seq0_instr", o_instruction, W0);
      check("seq0_pc",    o_pc,          32'h4);
      check("seq0_halt",  {31'b0, o_halt}, 32'h0);
      tick();
      check("seq1_instr", o_instruction, W1);
      check("seq1_pc",    o_pc,          32'h8);
      tick();
      check("halt_instr", o_instruction, HALT);
      check("halt_flag",  {31'b0, o_halt}, 32'h1);
      check("halt_pc",    o_pc,          32'hC);
      check("halt_state", {30'b0, o_state}, 32'h2);
      tick();
      check("halted_nop",   o_instruction, 32'h0);
      check("halted_flag",  {31'b0, o_halt}, 32'h0);
      check("halted_state", {30'b0, o_state}, 32'h2);

      // Restart, then stall three cycles with a jump asserted
      start_pulse();
      check("restart_state", {30'b0, o_state}, 32'h1);
      tick();
      check("restart_instr", o_instruction, W0);
      check("restart_pc",    o_pc,          32'h4);
      i_stall        = 1'b1;
      i_jump         = 1'b1;
      i_jump_address = 32'h0000_0100;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_instr", o_instruction, W0);
         check("stall_pc",    o_pc,          32'h4);
      end

      // Jump to 0xB at PC 4: target masked to 8
      i_stall        = 1'b0;
      i_jump_address = 32'h0000_000B;
      tick();
      i_jump = 1'b0;
`ifdef IF_JUMP_FLUSH_EN
      check("slot_instr", o_instruction, 32'h0);
      check("slot_halt",  {31'b0, o_halt}, 32'h0);
`else
      check("slot_instr", o_instruction, W1);
      check("slot_pc",    o_pc,          32'h8);
`endif
      tick();
      check("jtgt_instr", o_instruction, HALT);
      check("jtgt_pc",    o_pc,          32'hC);
      check("jtgt_state", {30'b0, o_state}, 32'h2);

      // Asynchronous reset in the middle of a RUN cycle
      start_pulse();
      tick();
      check("prerst_instr", o_instruction, W0);
      #3 i_reset = 1'b0;
      #1;
      check("arst_instr", o_instruction, 32'h0);
      check("arst_pc",    o_pc,          32'h0);
      check("arst_halt",  {31'b0, o_halt}, 32'h0);
      check("arst_state", {30'b0, o_state}, 32'h0);
      #2 i_reset = 1'b1;
      tick();
      check("postrst_state", {30'b0, o_state}, 32'h0);
      start_pulse();
      tick();
      check("resume_instr", o_instruction, W0);
      check("resume_pc",    o_pc,          32'h4);
      tick();
      check("resume1_instr", o_instruction, W1);

      // Load attempted during RUN must be ignored
      i_load_en   = 1'b1;
      i_load_addr = 8'd0;
      i_load_data = 32'h1234_5678;
      tick();
      i_load_en   = 1'b0;
      check("runload_state", {30'b0, o_state}, 32'h2);
      start_pulse();
      tick();
      check("runload_ignored", o_instruction, W0);
      tick();
      tick();
      check("runload_halt_state", {30'b0, o_state}, 32'h2);

      // Load and start on the same edge in HALTED
      i_load_en   = 1'b1;
      i_load_addr = 8'd0;
      i_load_data = WNEW;
      i_start     = 1'b1;
      tick();
      i_load_en   = 1'b0;
      i_start     = 1'b0;
      check("ldstart_state", {30'b0, o_state}, 32'h1);
      tick();
      check("ldstart_instr", o_instruction, WNEW);
      check("ldstart_pc",    o_pc,          32'h4);

      // Jump to top of address space: index 255, PC+4 wraps to 0
      i_jump         = 1'b1;
      i_jump_address = 32'hFFFF_FFFE;
      tick();
      i_jump = 1'b0;
`ifdef IF_JUMP_FLUSH_EN
      check("wslot_instr", o_instruction, 32'h0);
`else
      check("wslot_instr", o_instruction, W1);
`endif
      tick();
      check("wrap_instr", o_instruction, W255);
      check("wrap_pc",    o_pc,          32'h0);
      tick();
      check("wrap_next_instr", o_instruction, WNEW);
      check("wrap_next_pc",    o_pc,          32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
